// File: rtl/drum_div.sv
// drum_div: sequential approximate signed divider built on the DRUM mantissa
// reduction. Both operands are cut down to K-bit unbiased mantissas, the
// mantissas go through a restoring divider (one quotient bit per cycle), and
// the quotient is rescaled by the exponent difference.
module drum_div #(
   parameter int N = 8,
   parameter int M = 8,
   parameter int K = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [M-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] r,
   output logic         dz
);

   localparam int unsigned KU = K;
   localparam int AW = $clog2(N);
   localparam int BW = $clog2(M);
   localparam int PW = $clog2(N);
   localparam int QW = $clog2(M);
   localparam int CW = $clog2(2 * K);
   localparam logic [N-1:0] R_MAX = {1'b0, {(N-1){1'b1}}};

   typedef enum logic [2:0] {IDLE, NORM, DIV, SCALE, DONE} state_t;

   state_t state, state_nx;

   // captured operands
   logic [N-1:0] a_q;
   logic [M-1:0] b_q;

   // normalisation results (combinational, valid in NORM)
   logic [N-1:0]  ma;
   logic [M-1:0]  mb;
   logic          sgn_c;
   int unsigned   ka, kb;
   logic [K-1:0]  a_m, b_m;
   logic [PW-1:0] p_c;
   logic [QW-1:0] q_c;

   // divider state
   logic          sgn_q;
   logic [PW-1:0] p_q;
   logic [QW-1:0] q_q;
   logic [2*K-1:0] dvd_q;
   logic [K-1:0]  dvs_q;
   logic [K-1:0]  rem_q;
   logic [2*K-1:0] quot_q;
   logic [CW-1:0] cnt_q;

   // one restoring step
   logic [K:0]    rem_sh;
   logic          ge;
   logic [K-1:0]  rem_nx;

   // rescaling
   int            s;
   int            sh_r;
   logic [N+2*K-1:0] q_ext;
   logic [N-1:0]  r_mag;

   // Magnitudes, leading-one positions and K-bit unbiased mantissas.
   always_comb begin
      ma    = a_q[N-1] ? ~a_q : a_q;
      mb    = b_q[M-1] ? ~b_q : b_q;
      sgn_c = a_q[N-1] ^ b_q[M-1];
      ka    = 0;
      kb    = 0;
      for (int unsigned i = 0; i < N; i++)
         if (ma[AW'(i)]) ka = i;
      for (int unsigned i = 0; i < M; i++)
         if (mb[BW'(i)]) kb = i;
      // Shifting the leading one down to bit K-1 and forcing bit 0 high gives
      // {1, next K-2 bits, 1}, the DRUM unbiased mantissa.
      if (ka > KU - 1) begin
         a_m = K'(ma >> (ka - (KU - 1))) | K'(1);
         p_c = PW'(ka - (KU - 1));
      end else begin
         a_m = ma[K-1:0];
         p_c = '0;
      end
      if (kb > KU - 1) begin
         b_m = K'(mb >> (kb - (KU - 1))) | K'(1);
         q_c = QW'(kb - (KU - 1));
      end else begin
         b_m = mb[K-1:0];
         q_c = '0;
      end
   end

   // Restoring division step: shift in the next dividend bit, subtract if it fits.
   always_comb begin
      rem_sh = {rem_q, dvd_q[2*K-1]};
      ge     = (rem_sh >= {1'b0, dvs_q});
      rem_nx = ge ? K'(rem_sh - {1'b0, dvs_q}) : K'(rem_sh);
   end

   // Rescale the quotient by s = p - q - K; large right shifts flush to zero.
   always_comb begin
      s     = int'(p_q) - int'(q_q) - K;
      sh_r  = -s;
      q_ext = {{N{1'b0}}, quot_q};
      if (s >= 0)
         r_mag = N'(q_ext << s);
      else if (sh_r >= 2 * K)
         r_mag = '0;
      else
         r_mag = N'(q_ext >> sh_r);
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = NORM;
         NORM:    state_nx = (mb == '0) ? DONE : DIV;
         DIV:     if (cnt_q == CW'(2 * K - 1)) state_nx = SCALE;
         SCALE:   state_nx = DONE;
         DONE:    state_nx = start ? NORM : IDLE;
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state == NORM) || (state == DIV) || (state == SCALE);
   assign done = (state == DONE);

   // Operand capture, divider datapath and result registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         sgn_q  <= 1'b0;
         p_q    <= '0;
         q_q    <= '0;
         dvd_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         quot_q <= '0;
         cnt_q  <= '0;
         r      <= '0;
         dz     <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_q <= a;
                  b_q <= b;
               end
            end
            NORM: begin
               sgn_q  <= sgn_c;
               p_q    <= p_c;
               q_q    <= q_c;
               dvd_q  <= {a_m, {K{1'b0}}};
               dvs_q  <= b_m;
               rem_q  <= '0;
               quot_q <= '0;
               cnt_q  <= '0;
               if (mb == '0) begin
                  r  <= sgn_c ? ~R_MAX : R_MAX;
                  dz <= 1'b1;
               end
            end
            DIV: begin
               rem_q  <= rem_nx;
               quot_q <= {quot_q[2*K-2:0], ge};
               dvd_q  <= dvd_q << 1;
               cnt_q  <= cnt_q + 1'b1;
            end
            SCALE: begin
               r  <= sgn_q ? ~r_mag : r_mag;
               dz <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_drum_div.sv
// tb_drum_div: directed bench for drum_div with hand-computed expected values.
module tb_drum_div;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       busy;
   logic       done;
   logic [7:0] r;
   logic       dz;

   int n_cmp = 0;
   int n_err = 0;

   drum_div #(.N(8), .M(8), .K(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .r     (r),
      .dz    (dz)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present operands with start at the current (negedge) time; return at the
   // negedge following the accepting edge with start released.
   task automatic launch(input logic [7:0] av, input logic [7:0] bv);
      a     = av;
      b     = bv;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Wait (bounded) for done; lat counts edges after the accepting edge.
   task automatic wait_done(input string tag, input int lat0, input logic [7:0] exp_r,
                            input logic exp_dz, input int exp_lat, input logic lat_exact);
      int lat;
      lat = lat0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_r"}, r, exp_r);
      check({tag, "_dz"}, dz, exp_dz);
      if (lat_exact) check({tag, "_lat"}, lat, exp_lat);
      else           check({tag, "_lat_max"}, (lat <= exp_lat), 1'b1);
   endtask

   task automatic run(input string tag, input logic [7:0] av, input logic [7:0] bv,
                      input logic [7:0] exp_r, input logic exp_dz);
      @(negedge clk);
      launch(av, bv);
      check({tag, "_busy"}, busy, 1'b1);
      if (exp_dz) wait_done(tag, 0, exp_r, exp_dz, 2, 1'b0);
      else        wait_done(tag, 0, exp_r, exp_dz, 10, 1'b1);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a     = '0;
      b     = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_dz", dz, 1'b0);
      check("rst_r", r, 8'h00);
      rst_n = 1'b1;

      // basic positive divide, then DONE returns to IDLE
      run("t1", 8'd100, 8'd5, 8'd20, 1'b0);
      @(negedge clk);
      check("t1_idle_done", done, 1'b0);
      check("t1_idle_busy", busy, 1'b0);

      // signs
      run("t2a", 8'h9B, 8'd5, 8'hEB, 1'b0);
      run("t2b", 8'h9B, 8'hFA, 8'd20, 1'b0);

      // divide by zero (+0 and -0)
      run("t3a", 8'd7, 8'h00, 8'h7F, 1'b1);
      run("t3b", 8'd7, 8'hFF, 8'h80, 1'b1);

      // truncation, zero dividend, large dividend
      run("t4a", 8'd6, 8'd4, 8'd1, 1'b0);
      run("t4b", 8'd0, 8'd3, 8'd0, 1'b0);
      run("t4c", 8'd127, 8'd1, 8'd120, 1'b0);
      run("t4d", 8'hFF, 8'd3, 8'hFF, 1'b0);

      // start during DIV is ignored; start in DONE is accepted back-to-back
      @(negedge clk);
      launch(8'd100, 8'd5);
      repeat (4) @(negedge clk);
      check("t5_busy_mid", busy, 1'b1);
      a     = 8'd3;
      b     = 8'd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("t5a", 5, 8'd20, 1'b0, 10, 1'b1);
      launch(8'd6, 8'd4);
      wait_done("t5b", 0, 8'd1, 1'b0, 10, 1'b1);

      // reset mid-DIV clears results and aborts; then a fresh op completes
      run("t6pre", 8'd7, 8'hFF, 8'h80, 1'b1);
      @(negedge clk);
      launch(8'd100, 8'd5);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t6_busy", busy, 1'b0);
      check("t6_done", done, 1'b0);
      check("t6_dz", dz, 1'b0);
      check("t6_r", r, 8'h00);
      run("t6post", 8'd100, 8'hFA, 8'hEB, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
